// File: rtl/button_pkg.sv
// button_pkg -- shared defaults and helpers for the button debouncer bank.
//
// Contents:
//   DEFAULT_CLOCKS        debounce hold time in clk cycles
//   DEFAULT_CLOCKS_CLOG2  debounce counter width
//   DEFAULT_LONG_CLOCKS   pressed cycles before a long-press pulse
//   DEFAULT_LONG_CLOG2    long-press counter width
//   clog2()               ceil(log2(value)), usable in constant expressions
package button_pkg;

    localparam int unsigned DEFAULT_CLOCKS       = 1024;
    localparam int unsigned DEFAULT_CLOCKS_CLOG2 = 10;
    localparam int unsigned DEFAULT_LONG_CLOCKS  = 1 << 20;
    localparam int unsigned DEFAULT_LONG_CLOG2   = 20;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) width = i + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/button_channel.sv
// button_channel -- one debounced button: 2-flop synchroniser, debounce
// counter, press/release edge pulses and a saturating long-press counter.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   btnIn       raw asynchronous pin
//   btnLevel    debounced pressed state (1 = pressed)
//   btnPress    one-cycle pulse on debounced 0->1
//   btnRelease  one-cycle pulse on debounced 1->0
//   btnLong     one-cycle pulse when held pressed for LONG_CLOCKS cycles
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned CLOCKS       = DEFAULT_CLOCKS,
    parameter int unsigned CLOCKS_CLOG2 = DEFAULT_CLOCKS_CLOG2,
    parameter int unsigned LONG_CLOCKS  = DEFAULT_LONG_CLOCKS,
    parameter int unsigned LONG_CLOG2   = DEFAULT_LONG_CLOG2,
    parameter int unsigned ACTIVE_LOW   = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btnIn,
    output logic btnLevel,
    output logic btnPress,
    output logic btnRelease,
    output logic btnLong
);

    // Never narrower than the counts require, even if the width parameter
    // passed in is too small (the long counter must hold LONG_CLOCKS itself).
    localparam int unsigned CW = (CLOCKS_CLOG2 > clog2(CLOCKS)) ?
                                 CLOCKS_CLOG2 : clog2(CLOCKS);
    localparam int unsigned LW = (LONG_CLOG2 > clog2(LONG_CLOCKS + 1)) ?
                                 LONG_CLOG2 : clog2(LONG_CLOCKS + 1);

    logic          pinPressed;
    logic [1:0]    syncReg;
    logic [CW-1:0] bounceCnt;
    logic [LW-1:0] longCnt;
    logic          differs;
    logic          settle;
    logic          falling;

    assign pinPressed = (ACTIVE_LOW != 0) ? ~btnIn : btnIn;

    always_comb begin
        differs = syncReg[1] ^ btnLevel;
        settle  = differs && (bounceCnt == CW'(CLOCKS - 1));
        falling = settle && btnLevel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncReg    <= '0;
            bounceCnt  <= '0;
            longCnt    <= '0;
            btnLevel   <= 1'b0;
            btnPress   <= 1'b0;
            btnRelease <= 1'b0;
            btnLong    <= 1'b0;
        end else begin
            syncReg <= {syncReg[0], pinPressed};

            if (!differs || settle) bounceCnt <= '0;
            else                    bounceCnt <= bounceCnt + CW'(1);

            btnLevel   <= btnLevel ^ settle;
            btnPress   <= settle && !btnLevel;
            btnRelease <= falling;

            // A release landing on the terminal long count wins: the counter
            // clears and the long pulse is withheld.
            if (!btnLevel || falling)               longCnt <= '0;
            else if (longCnt != LW'(LONG_CLOCKS))   longCnt <= longCnt + LW'(1);

            btnLong <= btnLevel && !falling && (longCnt == LW'(LONG_CLOCKS - 1));
        end
    end

endmodule

// File: rtl/button_bank.sv
// button_bank -- N_BTN independent debounced buttons with press, release and
// long-press pulses, plus a combined event flag.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   btn_in       raw asynchronous pins
//   btn_level    debounced pressed state per channel (1 = pressed)
//   btn_press    one-cycle pulse per channel on debounced press
//   btn_release  one-cycle pulse per channel on debounced release
//   btn_long     one-cycle pulse per channel after LONG_CLOCKS held cycles
//   any_event    OR of every press, release and long pulse this cycle
module button_bank
    import button_pkg::*;
#(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned CLOCKS       = DEFAULT_CLOCKS,
    parameter int unsigned CLOCKS_CLOG2 = DEFAULT_CLOCKS_CLOG2,
    parameter int unsigned LONG_CLOCKS  = DEFAULT_LONG_CLOCKS,
    parameter int unsigned LONG_CLOG2   = DEFAULT_LONG_CLOG2,
    parameter int unsigned ACTIVE_LOW   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic             any_event
);

    for (genvar i = 0; i < N_BTN; i++) begin : gChannel
        button_channel #(
            .CLOCKS       (CLOCKS),
            .CLOCKS_CLOG2 (CLOCKS_CLOG2),
            .LONG_CLOCKS  (LONG_CLOCKS),
            .LONG_CLOG2   (LONG_CLOG2),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) uChannel (
            .clk        (clk),
            .rst_n      (rst_n),
            .btnIn      (btn_in[i]),
            .btnLevel   (btn_level[i]),
            .btnPress   (btn_press[i]),
            .btnRelease (btn_release[i]),
            .btnLong    (btn_long[i])
        );
    end

    // All inputs are flop outputs, so this tracks the pulses with no added latency.
    assign any_event = |{btn_press, btn_release, btn_long};

endmodule

// File: tb/tb_button_bank.sv
module tb_button_bank;

    localparam int NB    = 4;
    localparam int CLK   = 4;
    localparam int LONGC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [NB-1:0] pins;
    logic [NB-1:0] pinsLow;
    logic [NB-1:0] level, press, rel, lng;
    logic          anyEv;
    logic [NB-1:0] levelL, pressL, relL, lngL;
    logic          anyEvL;

    assign pinsLow = ~pins;

    button_bank #(
        .N_BTN(NB), .CLOCKS(CLK), .CLOCKS_CLOG2(2),
        .LONG_CLOCKS(LONGC), .LONG_CLOG2(5), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(pins),
        .btn_level(level), .btn_press(press), .btn_release(rel),
        .btn_long(lng), .any_event(anyEv)
    );

    button_bank #(
        .N_BTN(NB), .CLOCKS(CLK), .CLOCKS_CLOG2(2),
        .LONG_CLOCKS(LONGC), .LONG_CLOG2(5), .ACTIVE_LOW(1)
    ) dutLow (
        .clk(clk), .rst_n(rst_n), .btn_in(pinsLow),
        .btn_level(levelL), .btn_press(pressL), .btn_release(relL),
        .btn_long(lngL), .any_event(anyEvL)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a channel flips when its last CLOCKS observations of the
    // pin (each seen two edges after sampling) all disagree with the level and
    // all came after the previous flip. Long fires LONGC edges after the rise.
    int          edgeIdx;
    logic [NB-1:0] pinAt [0:7];
    logic [NB-1:0] mLevel, mPress, mRel, mLong;
    int          lastFlip [NB];
    int          riseEdge [NB];

    task automatic modelReset();
        edgeIdx = 0;
        mLevel = '0; mPress = '0; mRel = '0; mLong = '0;
        for (int c = 0; c < NB; c++) begin
            lastFlip[c] = -100;
            riseEdge[c] = -100;
        end
        for (int k = 0; k < 8; k++) pinAt[k] = '0;
    endtask

    task automatic modelStep(input logic [NB-1:0] p);
        pinAt[edgeIdx % 8] = p;
        for (int c = 0; c < NB; c++) begin
            bit allDiff;
            bit flip;
            logic obs;
            allDiff = 1'b1;
            for (int k = 0; k < CLK; k++) begin
                int e;
                e = edgeIdx - k;
                obs = (e < 2) ? 1'b0 : pinAt[(e - 2) % 8][c];
                if (obs == mLevel[c]) allDiff = 1'b0;
            end
            flip = allDiff && (edgeIdx - lastFlip[c] >= CLK);
            mPress[c] = flip && !mLevel[c];
            mRel[c]   = flip && mLevel[c];
            if (flip) begin
                mLevel[c]   = ~mLevel[c];
                lastFlip[c] = edgeIdx;
                if (mLevel[c]) riseEdge[c] = edgeIdx;
            end
            mLong[c] = mLevel[c] && (edgeIdx - riseEdge[c] == LONGC);
        end
        edgeIdx++;
    endtask

    task automatic stepCycle(input logic [NB-1:0] p);
        logic mAny;
        pins = p;
        @(posedge clk);
        modelStep(p);
        #1;
        mAny = |{mPress, mRel, mLong};
        checkVal("level",      level,  mLevel);
        checkVal("press",      press,  mPress);
        checkVal("release",    rel,    mRel);
        checkVal("long",       lng,    mLong);
        checkVal("any",        anyEv,  mAny);
        checkVal("lowLevel",   levelL, mLevel);
        checkVal("lowPress",   pressL, mPress);
        checkVal("lowRelease", relL,   mRel);
        checkVal("lowLong",    lngL,   mLong);
        checkVal("lowAny",     anyEvL, mAny);
    endtask

    task automatic doReset();
        #2 rst_n = 1'b0;
        #1;
        checkVal("rstZero",    {level, press, rel, lng, anyEv}, '0);
        checkVal("rstZeroLow", {levelL, pressL, relL, lngL, anyEvL}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    int pressEdge, pressLowEdge, anyAtPress, longEdge, releaseEdge;
    int pressCount, releaseCount, longCount, firstAnyEdge;
    logic [NB-1:0] pressVal;
    logic [NB-1:0] bounceTbl;
    logic [NB-1:0] target;
    logic [NB-1:0] drive;

    initial begin
        void'($urandom(32'd20240611));
        rst_n = 1'b0;
        pins  = '0;
        modelReset();
        @(posedge clk);
        #1;
        checkVal("initZero",    {level, press, rel, lng, anyEv}, '0);
        checkVal("initZeroLow", {levelL, pressL, relL, lngL, anyEvL}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean step on channel 0, both polarities.
        pressEdge = 0; pressLowEdge = 0; anyAtPress = 0;
        for (int i = 1; i <= 10; i++) begin
            stepCycle(4'b0001);
            if (press[0] && pressEdge == 0) begin
                pressEdge  = i;
                anyAtPress = int'(anyEv);
            end
            if (pressL[0] && pressLowEdge == 0) pressLowEdge = i;
        end
        checkVal("stepLatency",   pressEdge, 6);
        checkVal("stepAnyEvent",  anyAtPress, 1);
        checkVal("activeLowLat",  pressLowEdge, 6);

        // Bounce on channel 1: 1,1,0,0,1,1,0,0 then held 1 from edge 9.
        doReset();
        bounceTbl = 4'b0011;
        pressEdge = 0; pressCount = 0; releaseCount = 0;
        for (int i = 1; i <= 25; i++) begin
            logic b;
            b = (i <= 8) ? bounceTbl[((i - 1) / 2) % 2 == 0 ? 0 : 2] : 1'b1;
            stepCycle({2'b00, b, 1'b0});
            if (press[1]) begin
                pressCount++;
                if (pressEdge == 0) pressEdge = i;
            end
            if (rel[1]) releaseCount++;
        end
        checkVal("bouncePressCnt", pressCount, 1);
        checkVal("bounceRelCnt",   releaseCount, 0);
        checkVal("bounceLatency",  pressEdge - 9 + 1, 6);

        // Long press on channel 2: held for edges 1..30.
        doReset();
        pressEdge = 0; longEdge = 0; releaseEdge = 0; longCount = 0;
        for (int i = 1; i <= 45; i++) begin
            stepCycle((i <= 30) ? 4'b0100 : 4'b0000);
            if (press[2] && pressEdge == 0) pressEdge = i;
            if (lng[2]) begin
                longCount++;
                if (longEdge == 0) longEdge = i;
            end
            if (rel[2] && releaseEdge == 0) releaseEdge = i;
        end
        checkVal("longPressEdge", pressEdge, 6);
        checkVal("longDelay",     longEdge - pressEdge, 16);
        checkVal("longCount",     longCount, 1);
        checkVal("longRelLat",    releaseEdge - 31 + 1, 6);

        // Channel 3 releases on the edge the long count would complete.
        doReset();
        releaseEdge = 0; longCount = 0;
        for (int i = 1; i <= 30; i++) begin
            stepCycle((i <= 16) ? 4'b1000 : 4'b0000);
            if (rel[3] && releaseEdge == 0) releaseEdge = i;
            if (lng[3]) longCount++;
        end
        checkVal("boundaryRelEdge", releaseEdge, 22);
        checkVal("boundaryNoLong",  longCount, 0);

        // Reset mid-count, then mid-long-press with all pins held.
        doReset();
        repeat (3) stepCycle(4'b1111);
        doReset();
        for (int i = 1; i <= 12; i++) stepCycle(4'b1111);
        checkVal("preResetLevel", level, 4'hF);
        doReset();
        pressEdge = 0; pressVal = '0; firstAnyEdge = 0; longEdge = 0;
        for (int i = 1; i <= 26; i++) begin
            stepCycle(4'b1111);
            if (anyEv && firstAnyEdge == 0) firstAnyEdge = i;
            if (press != '0 && pressEdge == 0) begin
                pressEdge = i;
                pressVal  = press;
            end
            if (lng != '0 && longEdge == 0) longEdge = i;
        end
        checkVal("rstPressEdge", pressEdge, 6);
        checkVal("rstPressAll",  pressVal, 4'hF);
        checkVal("rstFirstAny",  firstAnyEdge, 6);
        checkVal("rstLongEdge",  longEdge, 22);

        // Randomised noisy presses with occasional resets.
        doReset();
        target = '0;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < NB; c++) begin
                if ($urandom_range(0, 99) < 2) target[c] = ~target[c];
                drive[c] = target[c] ^ ($urandom_range(0, 99) < 6);
            end
            stepCycle(drive);
            if ($urandom_range(0, 999) == 0) doReset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
